stopwatch_ctrl: RTL

Single-clock sequencer for the stopwatch seconds register. It replaces gated-clock counting with tick enables. It decodes mode switches and the debounced pause button, then runs the count-up / adjust / countdown state machine. It computes the next seconds value and issues a one-cycle load strobe to the seconds register. The seconds register feeds digitDivider.

---
 rtl/stopwatch_pkg.sv | 30 +++
 rtl/stopwatch_ctrl_if.sv | 28 ++
 rtl/stopwatch_step_calc.sv | 61 ++++++
 rtl/stopwatch_ctrl.sv | 133 +++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared constants, state and mode encodings for the
// stopwatch seconds sequencer (stopwatch_ctrl and its step calculator).
package stopwatch_pkg;

   localparam int SECS_W_DEF    = 12;
   localparam int SECS_PER_MIN  = 60;
   localparam int SECS_PER_HOUR = 3600;
   localparam int MAX_SECS_DEF  = SECS_PER_HOUR - 1;  // 59:59

   typedef enum logic [2:0] {
      S_INIT    = 3'd0,
      S_RUN     = 3'd1,
      S_PAUSED  = 3'd2,
      S_EXPIRED = 3'd3
   } state_t;

   typedef enum logic [1:0] {
      MODE_UP   = 2'd0,
      MODE_ADJ  = 2'd1,
      MODE_DOWN = 2'd2,
      MODE_HOLD = 2'd3
   } mode_t;

   // Per-digit blank masks, digit order {min_hi, min_lo, sec_hi, sec_lo}
   localparam logic [3:0] BLANK_NONE = 4'b0000;
   localparam logic [3:0] BLANK_MIN  = 4'b1100;
   localparam logic [3:0] BLANK_SEC  = 4'b0011;
   localparam logic [3:0] BLANK_ALL  = 4'b1111;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: tick/button/switch inputs and seconds-register load
// outputs of the stopwatch sequencer. 'slave' is the sequencer's view,
// 'master' is the surrounding system's view.
interface stopwatch_ctrl_if import stopwatch_pkg::*; #(
   parameter int SECS_W = SECS_W_DEF
);
   logic              tick_1hz;
   logic              tick_2hz;
   logic              btn_pause;
   logic [2:0]        sw;
   logic [SECS_W-1:0] secs_in;
   logic [SECS_W-1:0] secs_next;
   logic              secs_load;
   logic [2:0]        state;
   logic              paused;
   logic              expired;
   logic [3:0]        blank;

   modport master (
      output tick_1hz, tick_2hz, btn_pause, sw, secs_in,
      input  secs_next, secs_load, state, paused, expired, blank
   );

   modport slave (
      input  tick_1hz, tick_2hz, btn_pause, sw, secs_in,
      output secs_next, secs_load, state, paused, expired, blank
   );
endinterface

// File: rtl/stopwatch_step_calc.sv
// stopwatch_step_calc: combinational next-seconds calculation for one
// active tick. Arithmetic is modulo MAX_SECS+1; out-of-range inputs are
// recovered to 0 (counting up) or MAX_SECS (counting down).
module stopwatch_step_calc import stopwatch_pkg::*; #(
   parameter int SECS_W   = SECS_W_DEF,
   parameter int MAX_SECS = MAX_SECS_DEF
) (
   input  mode_t             i_mode,
   input  logic              i_unit,     // 0 = minutes, 1 = seconds
   input  logic [SECS_W-1:0] i_secs,
   output logic [SECS_W-1:0] o_next,
   output logic              o_load_ok,
   output logic              o_at_end
);
   // One extra bit so secs+60 on a corrupt value cannot overflow
   localparam logic [SECS_W:0] LIM    = (SECS_W+1)'(MAX_SECS);
   localparam logic [SECS_W:0] LIM_P1 = (SECS_W+1)'(MAX_SECS + 1);
   localparam logic [SECS_W:0] STEP_S = (SECS_W+1)'(1);
   localparam logic [SECS_W:0] STEP_M = (SECS_W+1)'(SECS_PER_MIN);

   logic [SECS_W:0] w_secs_ext;
   assign w_secs_ext = {1'b0, i_secs};

   function automatic logic [SECS_W-1:0] wrap_add(input logic [SECS_W:0] s,
                                                   input logic [SECS_W:0] step);
      logic [SECS_W:0] sum;
      sum = s + step;
      if (s > LIM)   return '0;
      if (sum > LIM) return SECS_W'(sum - LIM_P1);
      return SECS_W'(sum);
   endfunction

   // Select arithmetic by mode; HOLD never loads
   always_comb begin
      o_next    = '0;
      o_load_ok = 1'b0;
      o_at_end  = 1'b0;
      case (i_mode)
         MODE_UP: begin
            o_next    = wrap_add(w_secs_ext, STEP_S);
            o_load_ok = 1'b1;
         end
         MODE_ADJ: begin
            o_next    = wrap_add(w_secs_ext, i_unit ? STEP_S : STEP_M);
            o_load_ok = 1'b1;
         end
         MODE_DOWN: begin
            if (w_secs_ext > LIM) begin
               o_next    = SECS_W'(MAX_SECS);
               o_load_ok = 1'b1;
            end else if (i_secs == '0) begin
               o_at_end  = 1'b1;
            end else begin
               o_next    = i_secs - 1'b1;
               o_load_ok = 1'b1;
            end
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: tick-enable sequencer for the stopwatch seconds register.
// Registers the mode switches and pause button, runs the INIT/RUN/PAUSED/
// EXPIRED state machine and issues one-cycle load strobes.
// Optional build macro STOPWATCH_BLINK_EN: blinks the adjusted digits in
// ADJUST mode and all digits in EXPIRED, toggling on tick_2hz.
module stopwatch_ctrl import stopwatch_pkg::*; #(
   parameter int SECS_W   = SECS_W_DEF,
   parameter int MAX_SECS = MAX_SECS_DEF
) (
   input logic              src_clk,
   input logic              src_rst,
   stopwatch_ctrl_if.slave  bus
);
   mode_t             r_mode;
   logic              r_unit;
   logic              r_btn_prev;
   logic              r_paused;
   state_t            r_state;
   logic [SECS_W-1:0] r_secs_next;
   logic              r_secs_load;
   logic              r_expired;

   logic              w_pause_edge;
   logic              w_paused_nxt;
   logic              w_tick;
   logic [SECS_W-1:0] w_calc_next;
   logic              w_calc_load_ok;
   logic              w_calc_at_end;
   logic [3:0]        w_blank;

   assign w_pause_edge = bus.btn_pause & ~r_btn_prev;
   assign w_paused_nxt = r_paused ^ w_pause_edge;
   // ADJUST steps at 2 Hz so the user can scroll quickly
   assign w_tick       = (r_mode == MODE_ADJ) ? bus.tick_2hz : bus.tick_1hz;

   stopwatch_step_calc #(
      .SECS_W   (SECS_W),
      .MAX_SECS (MAX_SECS)
   ) u_step (
      .i_mode    (r_mode),
      .i_unit    (r_unit),
      .i_secs    (bus.secs_in),
      .o_next    (w_calc_next),
      .o_load_ok (w_calc_load_ok),
      .o_at_end  (w_calc_at_end)
   );

   // Register switches, button history and the pause toggle
   always_ff @(posedge src_clk) begin
      if (src_rst) begin
         r_mode     <= MODE_UP;
         r_unit     <= 1'b0;
         r_btn_prev <= 1'b0;
         r_paused   <= 1'b0;
      end else begin
         r_mode     <= mode_t'(bus.sw[1:0]);
         r_unit     <= bus.sw[2];
         r_btn_prev <= bus.btn_pause;
         r_paused   <= w_paused_nxt;
      end
   end

   // Sequencer FSM with registered load/expired strobes
   always_ff @(posedge src_clk) begin
      if (src_rst) begin
         r_state     <= S_INIT;
         r_secs_next <= '0;
         r_secs_load <= 1'b0;
         r_expired   <= 1'b0;
      end else begin
         r_secs_load <= 1'b0;
         r_expired   <= 1'b0;
         case (r_state)
            S_INIT: begin
               r_secs_next <= '0;
               r_secs_load <= 1'b1;
               r_state     <= S_RUN;
            end
            S_RUN: begin
               // A pause edge outranks a coincident tick
               if (w_pause_edge || r_paused) begin
                  r_state <= w_paused_nxt ? S_PAUSED : S_RUN;
               end else if (w_tick) begin
                  if (w_calc_load_ok) begin
                     r_secs_next <= w_calc_next;
                     r_secs_load <= 1'b1;
                  end
                  if (w_calc_at_end) begin
                     r_expired <= 1'b1;
                     r_state   <= S_EXPIRED;
                  end
               end
            end
            S_PAUSED: begin
               if (!w_paused_nxt) r_state <= S_RUN;
            end
            S_EXPIRED: begin
               if (r_mode != MODE_DOWN || w_pause_edge) r_state <= S_RUN;
            end
            default: r_state <= S_INIT;
         endcase
      end
   end

`ifdef STOPWATCH_BLINK_EN
   logic r_blink;

   // Blink phase follows the 2 Hz tick
   always_ff @(posedge src_clk) begin
      if (src_rst)           r_blink <= 1'b0;
      else if (bus.tick_2hz) r_blink <= ~r_blink;
   end

   // Decode blank mask from state, mode and blink phase
   always_comb begin
      w_blank = BLANK_NONE;
      if (r_blink) begin
         if (r_state == S_EXPIRED)   w_blank = BLANK_ALL;
         else if (r_mode == MODE_ADJ) w_blank = r_unit ? BLANK_SEC : BLANK_MIN;
      end
   end
`else
   assign w_blank = BLANK_NONE;
`endif

   assign bus.secs_next = r_secs_next;
   assign bus.secs_load = r_secs_load;
   assign bus.state     = r_state;
   assign bus.paused    = r_paused;
   assign bus.expired   = r_expired;
   assign bus.blank     = w_blank;

endmodule
